// File: rtl/vending_machine_param_pkg.sv
// vm_pkg: shared state encoding, coin codes and coin decoding for the vending controller
package vm_pkg;
    typedef enum logic [2:0] {S_IDLE, S_PAY, S_VEND, S_CHANGE, S_REFUND} state_e;
    localparam logic [2:0] COIN_1  = 3'b001;
    localparam logic [2:0] COIN_5  = 3'b010;
    localparam logic [2:0] COIN_10 = 3'b100;
    typedef struct packed {
        logic       ok;
        logic [3:0] value;
    } coin_t;
    function automatic coin_t coin_value(input logic [2:0] code);
        coin_t c;
        c.ok    = code inside {COIN_1, COIN_5, COIN_10};
        c.value = code == COIN_1 ? 4'd1 : code == COIN_5 ? 4'd5 : code == COIN_10 ? 4'd10 : 4'd0;
        return c;
    endfunction
endpackage

// File: rtl/vending_machine_param_if.sv
// vending_machine_param_if: purchase, coin, restock and status signals of the vending controller
interface vending_machine_param_if #(
    parameter int NUM_ITEMS = 5,
    parameter int SEL_W     = 3,
    parameter int QTY_W     = 2,
    parameter int STOCK_W   = 4,
    parameter int CREDIT_W  = 7
);
    logic                         sel_valid;
    logic [SEL_W-1:0]             item_sel;
    logic [QTY_W-1:0]             amt_sel;
    logic                         coin_valid;
    logic [2:0]                   coin;
    logic                         confirm;
    logic                         cancel;
    logic                         restock;
    logic [NUM_ITEMS*STOCK_W-1:0] stock;
    logic [CREDIT_W-1:0]          credit;
    logic                         vend_valid;
    logic [SEL_W-1:0]             vend_item;
    logic [QTY_W-1:0]             vend_qty;
    logic                         change_valid;
    logic [CREDIT_W-1:0]          change;
    logic                         coin_reject;
    logic                         err;
    logic [2:0]                   state;
    modport master (
        output sel_valid, item_sel, amt_sel, coin_valid, coin, confirm, cancel, restock,
        input  stock, credit, vend_valid, vend_item, vend_qty, change_valid, change, coin_reject, err, state
    );
    modport slave (
        input  sel_valid, item_sel, amt_sel, coin_valid, coin, confirm, cancel, restock,
        output stock, credit, vend_valid, vend_item, vend_qty, change_valid, change, coin_reject, err, state
    );
endinterface

// File: rtl/vending_machine_param_stock_bank.sv
// vm_stock_bank: per-item stock counters with saturating restock and vend decrement
module vm_stock_bank #(
    parameter int NUM_ITEMS  = 5,
    parameter int SEL_W      = 3,
    parameter int QTY_W      = 2,
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         restock_i,
    input  logic [SEL_W-1:0]             rs_item_i,
    input  logic [QTY_W-1:0]             rs_amt_i,
    input  logic                         vend_i,
    input  logic [SEL_W-1:0]             vd_item_i,
    input  logic [QTY_W-1:0]             vd_qty_i,
    input  logic [SEL_W-1:0]             sel_item_i,
    output logic [STOCK_W-1:0]           sel_stock_o,
    output logic [NUM_ITEMS*STOCK_W-1:0] stock_o
);
    for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_slot
        logic [STOCK_W-1:0] stk_q;
        logic [STOCK_W:0]   sum;
        logic [STOCK_W-1:0] dec;
        assign sum = {1'b0, stk_q} + (STOCK_W+1)'(rs_amt_i);
        assign dec = STOCK_W'(vd_qty_i) > stk_q ? '0 : stk_q - STOCK_W'(vd_qty_i);
        always_ff @(posedge clk) begin
            if (rst) stk_q <= STOCK_W'(INIT_STOCK);
            else if (restock_i && int'(rs_item_i) == i) stk_q <= sum[STOCK_W] ? '1 : sum[STOCK_W-1:0];
            else if (vend_i && int'(vd_item_i) == i) stk_q <= dec;
        end
        assign stock_o[i*STOCK_W +: STOCK_W] = stk_q;
    end
    assign sel_stock_o = stock_o[int'(sel_item_i)*STOCK_W +: STOCK_W];
endmodule

// File: rtl/vending_machine_param.sv
// vending_machine_param: parametrised vending controller with credit, change, refund and restock
module vending_machine_param
    import vm_pkg::*;
#(
    parameter int                         NUM_ITEMS  = 5,
    parameter int                         SEL_W      = 3,
    parameter int                         QTY_W      = 2,
    parameter int                         STOCK_W    = 4,
    parameter int                         INIT_STOCK = 3,
    parameter int                         PRICE_W    = 6,
    parameter logic [NUM_ITEMS*PRICE_W-1:0] PRICES   = {6'd25, 6'd20, 6'd15, 6'd10, 6'd5},
    parameter int                         CREDIT_W   = 7
) (
    input logic                  clk,
    input logic                  rst,
    vending_machine_param_if.slave bus
);
    state_e                       state_q;
    logic [SEL_W-1:0]             item_q, vend_item_q, sel_idx;
    logic [QTY_W-1:0]             qty_q, vend_qty_q;
    logic [CREDIT_W-1:0]          credit_q, cost_q, change_q, credit_acc, sel_cost;
    logic                         vend_valid_q, change_valid_q, coin_reject_q, err_q;
    logic                         coin_ok, item_ok, sel_ok;
    logic [CREDIT_W:0]            coin_sum;
    logic [STOCK_W-1:0]           sel_stock;
    logic [PRICE_W-1:0]           price;
    logic [NUM_ITEMS*STOCK_W-1:0] stock;
    coin_t                        cv;
    assign cv         = coin_value(bus.coin);
    assign coin_sum   = {1'b0, credit_q} + (CREDIT_W+1)'(cv.value);
    assign coin_ok    = bus.coin_valid && cv.ok && state_q == S_PAY && !coin_sum[CREDIT_W];
    assign credit_acc = coin_ok ? coin_sum[CREDIT_W-1:0] : credit_q;
    assign item_ok    = int'(bus.item_sel) < NUM_ITEMS;
    assign sel_idx    = item_ok ? bus.item_sel : '0;
    assign sel_ok     = item_ok && bus.amt_sel != '0 &&
                        {{STOCK_W{1'b0}}, bus.amt_sel} <= {{QTY_W{1'b0}}, sel_stock};
    assign price      = PRICES[int'(sel_idx)*PRICE_W +: PRICE_W];
    assign sel_cost   = CREDIT_W'(price) * CREDIT_W'(bus.amt_sel);
    vm_stock_bank #(
        .NUM_ITEMS(NUM_ITEMS), .SEL_W(SEL_W), .QTY_W(QTY_W), .STOCK_W(STOCK_W), .INIT_STOCK(INIT_STOCK)
    ) u_bank (
        .clk(clk),
        .rst(rst),
        .restock_i(state_q == S_IDLE && bus.restock && item_ok),
        .rs_item_i(bus.item_sel),
        .rs_amt_i(bus.amt_sel),
        .vend_i(state_q == S_VEND),
        .vd_item_i(item_q),
        .vd_qty_i(qty_q),
        .sel_item_i(sel_idx),
        .sel_stock_o(sel_stock),
        .stock_o(stock)
    );
    // refund on cancel returns any coin accepted in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            item_q         <= '0;
            qty_q          <= '0;
            cost_q         <= '0;
            credit_q       <= '0;
            change_q       <= '0;
            vend_item_q    <= '0;
            vend_qty_q     <= '0;
            vend_valid_q   <= 1'b0;
            change_valid_q <= 1'b0;
            coin_reject_q  <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            vend_valid_q   <= 1'b0;
            change_valid_q <= 1'b0;
            err_q          <= 1'b0;
            coin_reject_q  <= bus.coin_valid && !coin_ok;
            credit_q       <= credit_acc;
            case (state_q)
                S_IDLE: begin
                    if (bus.restock) err_q <= !item_ok;
                    else if (bus.sel_valid && !sel_ok) err_q <= 1'b1;
                    else if (bus.sel_valid) begin
                        item_q  <= bus.item_sel;
                        qty_q   <= bus.amt_sel;
                        cost_q  <= sel_cost;
                        state_q <= S_PAY;
                    end
                end
                S_PAY: begin
                    if (bus.cancel) begin
                        state_q        <= S_REFUND;
                        change_valid_q <= 1'b1;
                        change_q       <= credit_acc;
                        credit_q       <= '0;
                    end else if (bus.confirm && credit_q >= cost_q) begin
                        state_q      <= S_VEND;
                        vend_valid_q <= 1'b1;
                        vend_item_q  <= item_q;
                        vend_qty_q   <= qty_q;
                    end
                end
                S_VEND: begin
                    state_q        <= S_CHANGE;
                    change_valid_q <= 1'b1;
                    change_q       <= credit_q - cost_q;
                    credit_q       <= '0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
    assign bus.stock        = stock;
    assign bus.credit       = credit_q;
    assign bus.vend_valid   = vend_valid_q;
    assign bus.vend_item    = vend_item_q;
    assign bus.vend_qty     = vend_qty_q;
    assign bus.change_valid = change_valid_q;
    assign bus.change       = change_q;
    assign bus.coin_reject  = coin_reject_q;
    assign bus.err          = err_q;
    assign bus.state        = state_q;
endmodule

// File: tb/tb_vending_machine_param.sv
// tb_vending_machine_param: randomized scoreboard bench against a behavioural vending model
module tb_vending_machine_param;
    localparam int N = 5;
    localparam int MAXC = 127;
    localparam int MAXS = 15;
    localparam int P_IDLE = 0, P_PAY = 1, P_VEND = 2, P_CHANGE = 3, P_REFUND = 4;
    localparam logic [2:0] C1 = 3'b001, C5 = 3'b010, C10 = 3'b100;
    typedef struct {
        int cyc;
        int a;
        int b;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    int   price[N] = '{5, 10, 15, 20, 25};
    int   mph, mcredit, mcost, mitem, mqty;
    int   mstock[N];
    int   cph, ccredit;
    int   cstock[N];
    int   eq[$], rq[$];
    ev_t  vq[$], cq[$];

    vending_machine_param_if vif ();
    vending_machine_param dut (.clk(clk), .rst(rst), .bus(vif));

    always #5 clk = ~clk;

    // expected values for the cycle that follows each edge
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        cph     <= mph;
        ccredit <= mcredit;
        cstock  <= mstock;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    function automatic int cval(input logic [2:0] c);
        case (c)
            C1:      return 1;
            C5:      return 5;
            C10:     return 10;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        mph = P_IDLE; mcredit = 0; mcost = 0; mitem = 0; mqty = 0;
        foreach (mstock[i]) mstock[i] = 3;
    endtask

    task automatic set_in(bit s, int it, int am, bit cv, logic [2:0] cd, bit cf, bit cn, bit rs);
        vif.sel_valid = s; vif.item_sel = 3'(it); vif.amt_sel = 2'(am);
        vif.coin_valid = cv; vif.coin = cd; vif.confirm = cf; vif.cancel = cn; vif.restock = rs;
    endtask

    task automatic drive(bit s, int it, int am, bit cv, logic [2:0] cd, bit cf, bit cn, bit rs);
        int v, pre, ph;
        @(posedge clk); #1;
        set_in(s, it, am, cv, cd, cf, cn, rs);
        ph = mph;
        pre = mcredit;
        if (cv) begin
            v = cval(cd);
            if (ph != P_PAY || v == 0 || mcredit + v > MAXC) rq.push_back(cyc + 1);
            else mcredit += v;
        end
        case (ph)
            P_IDLE: begin
                if (rs) begin
                    if (it >= N) eq.push_back(cyc + 1);
                    else mstock[it] = (mstock[it] + am > MAXS) ? MAXS : mstock[it] + am;
                end else if (s) begin
                    if (it >= N || am == 0 || am > mstock[it]) eq.push_back(cyc + 1);
                    else begin
                        mitem = it; mqty = am; mcost = price[it] * am; mph = P_PAY;
                    end
                end
            end
            P_PAY: begin
                if (cn) begin
                    cq.push_back('{cyc + 1, mcredit, 0});
                    mcredit = 0; mph = P_REFUND;
                end else if (cf && pre >= mcost) begin
                    vq.push_back('{cyc + 1, mitem, mqty});
                    mph = P_VEND;
                end
            end
            P_VEND: begin
                mstock[mitem] -= mqty;
                cq.push_back('{cyc + 1, mcredit - mcost, 0});
                mcredit = 0; mph = P_CHANGE;
            end
            default: mph = P_IDLE;
        endcase
    endtask

    task automatic idle();        drive(0, 0, 0, 0, 3'b000, 0, 0, 0); endtask
    task automatic sel(int it, int am); drive(1, it, am, 0, 3'b000, 0, 0, 0); endtask
    task automatic coin(logic [2:0] cd); drive(0, 0, 0, 1, cd, 0, 0, 0); endtask
    task automatic conf();        drive(0, 0, 0, 0, 3'b000, 1, 0, 0); endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        set_in(0, 0, 0, 0, 3'b000, 0, 0, 0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        bit  e;
        ev_t v;
        if (mon_en) begin
            chk("state", int'(vif.state), cph);
            chk("credit", int'(vif.credit), ccredit);
            for (int i = 0; i < N; i++) chk("stock", int'(vif.stock[i*4 +: 4]), cstock[i]);
            e = eq.size() > 0 && eq[0] == cyc;
            chk("err_pulse", int'(vif.err), int'(e));
            if (e) void'(eq.pop_front());
            e = rq.size() > 0 && rq[0] == cyc;
            chk("coin_reject_pulse", int'(vif.coin_reject), int'(e));
            if (e) void'(rq.pop_front());
            e = vq.size() > 0 && vq[0].cyc == cyc;
            chk("vend_pulse", int'(vif.vend_valid), int'(e));
            if (e) begin
                v = vq.pop_front();
                chk("vend_item", int'(vif.vend_item), v.a);
                chk("vend_qty", int'(vif.vend_qty), v.b);
            end
            e = cq.size() > 0 && cq[0].cyc == cyc;
            chk("change_pulse", int'(vif.change_valid), int'(e));
            if (e) begin
                v = cq.pop_front();
                chk("change_amt", int'(vif.change), v.a);
            end
        end
    end

    initial begin
        set_in(0, 0, 0, 0, 3'b000, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        repeat (3) idle();
        @(negedge clk);
        chk("rst_state", int'(vif.state), 0);
        chk("rst_credit", int'(vif.credit), 0);
        chk("rst_stock2", int'(vif.stock[11:8]), 3);
        chk("rst_pulses", int'({vif.vend_valid, vif.change_valid, vif.coin_reject, vif.err}), 0);
        sel(2, 2); coin(C10); coin(C10); coin(C10); coin(C5); idle();
        @(negedge clk);
        chk("credit_35", int'(vif.credit), 35);
        conf(); repeat (4) idle();
        @(negedge clk);
        chk("stock2_after_vend", int'(vif.stock[11:8]), 1);
        sel(2, 2); sel(7, 1); coin(C10); idle();
        sel(0, 1); coin(C10); drive(0, 0, 0, 0, 3'b000, 1, 1, 0); repeat (3) idle();
        @(negedge clk);
        chk("stock0_after_refund", int'(vif.stock[3:0]), 3);
        sel(4, 3);
        repeat (12) coin(C10);
        coin(C10); idle();
        @(negedge clk);
        chk("credit_120", int'(vif.credit), 120);
        conf(); repeat (4) idle();
        do_reset();
        repeat (5) drive(0, 4, 3, 0, 3'b000, 0, 0, 1);
        idle();
        @(negedge clk);
        chk("stock4_saturated", int'(vif.stock[19:16]), 15);
        sel(0, 1); coin(C10); coin(C5); idle();
        @(negedge clk);
        chk("credit_15", int'(vif.credit), 15);
        do_reset(); idle();
        @(negedge clk);
        chk("reset_credit", int'(vif.credit), 0);
        chk("reset_stock4", int'(vif.stock[19:16]), 3);
        chk("reset_state", int'(vif.state), 0);
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            else drive($urandom_range(0, 3) == 0, $urandom_range(0, 7), $urandom_range(0, 3),
                       $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), $urandom_range(0, 9) == 0,
                       $urandom_range(0, 29) == 0, $urandom_range(0, 19) == 0);
        end
        repeat (6) idle();
        @(negedge clk);
        chk("pending_events", eq.size() + rq.size() + vq.size() + cq.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
